class_sum_accumulator: RTL

// - Downstream consumer of the packed clause-weight store. Sweeps clause_no 0..clauses-1 into the store,

---
 rtl/cotm_pkg.sv | 36 +++
 rtl/cotm_tag_pipe.sv | 30 +++
 rtl/class_sum_accumulator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cotm_pkg.sv
// Shared constants, FSM state type and clamp helper for the class-sum accumulator.
package cotm_pkg;

    localparam int CLAUSEN    = 140;
    localparam int NCLASS     = 10;
    localparam int WEIGHT_W   = 9;
    localparam int SUM_W      = 18;
    localparam int WEIGHT_LAT = 3;
    localparam int T_CLIP     = 127;
    localparam int CLASS_W    = $clog2(NCLASS);
    localparam int CLW        = $clog2(CLAUSEN) + 1;
    localparam int CIW        = $clog2(CLAUSEN);
    localparam int DRAIN_W    = $clog2(WEIGHT_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic signed [SUM_W-1:0] clip_sum(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = SUM_W'(T_CLIP);
        lo = -hi;
        if (v > hi) begin
            clip_sum = hi;
        end else if (v < lo) begin
            clip_sum = lo;
        end else begin
            clip_sum = v;
        end
    endfunction

endpackage

// File: rtl/cotm_tag_pipe.sv
// {valid,fire} shift register that keeps each issued clause tag aligned with its returning weight.
module cotm_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_fire,
    output logic out_valid,
    output logic out_fire
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] fire_r;

    // Shift one stage per clock; DEPTH must be at least 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            fire_r  <= {DEPTH{1'b0}};
        end else begin
            valid_r <= {valid_r[DEPTH-2:0], push_valid};
            fire_r  <= {fire_r[DEPTH-2:0], push_fire};
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_fire  = fire_r[DEPTH-1];

endmodule

// File: rtl/class_sum_accumulator.sv
// Sweeps clause_no over the external weight store, sums fired weights and tracks the best class.
// Build macro CLASS_SUM_CLIP_EN clamps class_sum and the compare value to +/-T_CLIP.
module class_sum_accumulator
    import cotm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       first_class,
    input  logic [CLASS_W-1:0]         class_id,
    input  logic [CLW-1:0]             clauses,
    input  logic [CLAUSEN-1:0]         clause_out,
    output logic [CLW-1:0]             clause_no,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic                       busy,
    output logic                       done,
    output logic signed [SUM_W-1:0]    class_sum,
    output logic [CLASS_W-1:0]         best_class,
    output logic signed [SUM_W-1:0]    best_sum
);

    state_t                  state_r;
    state_t                  state_s;
    logic                    first_class_r;
    logic [CLASS_W-1:0]      class_id_r;
    logic [CLW-1:0]          clauses_r;
    logic [CLAUSEN-1:0]      clause_out_r;
    logic signed [SUM_W-1:0] acc_r;
    logic signed [SUM_W-1:0] sum_new_s;
    logic signed [SUM_W-1:0] weight_ext_s;
    logic [DRAIN_W-1:0]      drain_cnt_r;
    logic                    push_valid_s;
    logic                    push_fire_s;
    logic                    tag_valid_s;
    logic                    tag_fire_s;
    logic                    last_issue_s;

    assign last_issue_s = (clause_no == (clauses_r - CLW'(1)));

    // Next-state and tag-push decode.
    always_comb begin
        state_s      = state_r;
        push_valid_s = 1'b0;
        push_fire_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (clauses == {CLW{1'b0}}) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                push_valid_s = 1'b1;
                push_fire_s  = clause_out_r[clause_no[CIW-1:0]];
                if (last_issue_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sign extension of the incoming weight and the value published at DONE.
    always_comb begin
        weight_ext_s = {{(SUM_W-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
`ifdef CLASS_SUM_CLIP_EN
        sum_new_s    = clip_sum(acc_r);
`else
        sum_new_s    = acc_r;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Drain countdown: preloaded outside DRAIN so DRAIN lasts exactly WEIGHT_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= DRAIN_W'(WEIGHT_LAT - 1);
        end else if (state_r != DRAIN) begin
            drain_cnt_r <= DRAIN_W'(WEIGHT_LAT - 1);
        end else if (drain_cnt_r != {DRAIN_W{1'b0}}) begin
            drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
        end
    end

    // Accumulator: cleared while idle, adds weights whose tag says the clause fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {SUM_W{1'b0}};
        end else if (state_r == IDLE) begin
            acc_r <= {SUM_W{1'b0}};
        end else if (tag_valid_s && tag_fire_s) begin
            acc_r <= acc_r + weight_ext_s;
        end
    end

    // Request latch, address counter, handshake and argmax outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_class_r <= 1'b0;
            class_id_r    <= {CLASS_W{1'b0}};
            clauses_r     <= {CLW{1'b0}};
            clause_out_r  <= {CLAUSEN{1'b0}};
            clause_no     <= {CLW{1'b0}};
            busy          <= 1'b0;
            done          <= 1'b0;
            class_sum     <= {SUM_W{1'b0}};
            best_class    <= {CLASS_W{1'b0}};
            best_sum      <= {SUM_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    clause_no <= {CLW{1'b0}};
                    if (start) begin
                        first_class_r <= first_class;
                        class_id_r    <= class_id;
                        clauses_r     <= (clauses > CLW'(CLAUSEN)) ? CLW'(CLAUSEN) : clauses;
                        clause_out_r  <= clause_out;
                        busy          <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (last_issue_s) begin
                        clause_no <= {CLW{1'b0}};
                    end else begin
                        clause_no <= clause_no + CLW'(1);
                    end
                end
                DONE: begin
                    class_sum <= sum_new_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    // Strict greater-than so a tie keeps the earlier class.
                    if (first_class_r || (sum_new_s > best_sum)) begin
                        best_sum   <= sum_new_s;
                        best_class <= class_id_r;
                    end
                end
                default: begin
                    clause_no <= {CLW{1'b0}};
                end
            endcase
        end
    end

    cotm_tag_pipe #(
        .DEPTH (WEIGHT_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid_s),
        .push_fire  (push_fire_s),
        .out_valid  (tag_valid_s),
        .out_fire   (tag_fire_s)
    );

endmodule
